// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: breathing-pattern duty generator (ramp up, hold, ramp down, hold) for a PWM dimmer
module pwm_fade_sequencer #(
    parameter int DW = 4,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [DW-1:0] min_duty,
    input  logic [DW-1:0] max_duty,
    input  logic [TW-1:0] step_div,
    input  logic [7:0]    hold_steps,
    input  logic [7:0]    loop_count,
    output logic [DW-1:0] duty,
    output logic          busy,
    output logic          cycle_done,
    output logic          cfg_err
);
    typedef enum logic [2:0] {IDLE, UP, HOLD_HI, DOWN, HOLD_LO} state_t;
    state_t        state;
    logic [DW-1:0] mn, mx;
    logic [TW-1:0] sd, timer, eff;
    logic [7:0]    hs, lc, hcnt, lcnt, lcnt_inc;
    logic          tick;
    always_comb begin
        eff = sd == '0 ? TW'(1) : sd;
        tick = timer == eff - TW'(1);
        lcnt_inc = lcnt + 8'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            duty <= '0;
            busy <= 1'b0;
            cycle_done <= 1'b0;
            cfg_err <= 1'b0;
            mn <= '0;
            mx <= '0;
            sd <= '0;
            hs <= '0;
            lc <= '0;
            timer <= '0;
            hcnt <= '0;
            lcnt <= '0;
        end else begin
            cycle_done <= 1'b0;
            cfg_err <= 1'b0;
            if (stop) begin
                state <= IDLE;
                duty <= '0;
                busy <= 1'b0;
                timer <= '0;
                hcnt <= '0;
            end else if (state == IDLE) begin
                if (start && min_duty < max_duty) begin
                    state <= UP;
                    busy <= 1'b1;
                    duty <= min_duty;
                    mn <= min_duty;
                    mx <= max_duty;
                    sd <= step_div;
                    hs <= hold_steps;
                    lc <= loop_count;
                    timer <= '0;
                    hcnt <= '0;
                    lcnt <= '0;
                end else if (start) begin
                    cfg_err <= 1'b1;
                end
            end else begin
                timer <= tick ? '0 : timer + TW'(1);
                if (tick) begin
                    case (state)
                        UP: begin
                            duty <= duty + DW'(1);
                            if (duty == mx - DW'(1)) begin
                                state <= HOLD_HI;
                                hcnt <= '0;
                            end
                        end
                        DOWN: begin
                            duty <= duty - DW'(1);
                            if (duty == mn + DW'(1)) begin
                                state <= HOLD_LO;
                                hcnt <= '0;
                            end
                        end
                        HOLD_HI: begin
                            hcnt <= hcnt == hs ? hcnt : hcnt + 8'd1;
                            if (hcnt == hs) state <= DOWN;
                        end
                        HOLD_LO: begin
                            if (hcnt == hs) begin
                                cycle_done <= 1'b1;
                                lcnt <= lcnt_inc;
                                if (lc != 8'd0 && lcnt_inc == lc) begin
                                    state <= IDLE;
                                    duty <= '0;
                                    busy <= 1'b0;
                                end else begin
                                    state <= UP;
                                end
                            end else begin
                                hcnt <= hcnt + 8'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb_pwm_fade_sequencer: scoreboard bench comparing per-cycle outputs against an analytic breath model
module tb_pwm_fade_sequencer;
    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic [3:0] min_duty, max_duty, duty;
    logic [15:0] step_div;
    logic [7:0] hold_steps, loop_count;
    logic       busy, cycle_done, cfg_err;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         n;
    typedef struct {
        int         at;
        logic [6:0] v;
        string      tag;
    } exp_t;
    exp_t q[$];
    pwm_fade_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .min_duty(min_duty), .max_duty(max_duty), .step_div(step_div),
        .hold_steps(hold_steps), .loop_count(loop_count),
        .duty(duty), .busy(busy), .cycle_done(cycle_done), .cfg_err(cfg_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, want);
        end
    endtask
    // packed as {busy, cycle_done, cfg_err, duty}
    function automatic logic [6:0] model(int k, int mn, int mx, int sd, int hs, int lc);
        int eff, up, hl, len, b, r, d;
        eff = sd == 0 ? 1 : sd;
        up = (mx - mn) * eff;
        hl = (hs + 1) * eff;
        len = 2 * up + 2 * hl;
        b = k / len;
        r = k % len;
        if (lc != 0 && b >= lc) return {1'b0, k == lc * len, 1'b0, 4'd0};
        d = r < up ? mn + r / eff : r < up + hl ? mx : r < 2 * up + hl ? mx - (r - up - hl) / eff : mn;
        return {1'b1, b > 0 && r == 0, 1'b0, 4'(d)};
    endfunction
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.at < cyc) check({e.tag, "_missed"}, cyc, e.at);
            else check(e.tag, {25'd0, busy, cycle_done, cfg_err, duty}, {25'd0, e.v});
        end
    end
    task automatic tick_n(int k);
        repeat (k) @(negedge clk);
    endtask
    task automatic start_seq(int mn, int mx, int sd, int hs, int lc, int nexp, string tag, output int t);
        t = cyc;
        min_duty = 4'(mn);
        max_duty = 4'(mx);
        step_div = 16'(sd);
        hold_steps = 8'(hs);
        loop_count = 8'(lc);
        start = 1'b1;
        for (int c = 1; c <= nexp; c++) q.push_back('{t + c, model(c - 1, mn, mx, sd, hs, lc), tag});
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic stop_now(string tag);
        int s;
        s = cyc;
        stop = 1'b1;
        q.push_back('{s + 1, 7'd0, tag});
        q.push_back('{s + 2, 7'd0, tag});
        @(negedge clk);
        stop = 1'b0;
    endtask
    task automatic bad_cfg(int mn, int mx, string tag);
        int s;
        s = cyc;
        min_duty = 4'(mn);
        max_duty = 4'(mx);
        start = 1'b1;
        q.push_back('{s + 1, 7'b0010000, tag});
        q.push_back('{s + 2, 7'd0, tag});
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic drain(int budget);
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask
    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        min_duty = '0;
        max_duty = '0;
        step_div = '0;
        hold_steps = '0;
        loop_count = '0;
        tick_n(3);
        check("reset", {25'd0, busy, cycle_done, cfg_err, duty}, 0);
        rst = 1'b0;
        tick_n(1);
        // single breath, with an ignored start and config changes mid-sequence
        start_seq(2, 5, 3, 1, 1, 40, "breath", n);
        tick_n(3);
        start = 1'b1;
        max_duty = 4'd15;
        min_duty = 4'd0;
        loop_count = 8'd0;
        tick_n(1);
        start = 1'b0;
        drain(100);
        // endless breathing, one step per cycle
        start_seq(0, 15, 0, 0, 0, 300 * 32 + 10, "loop", n);
        tick_n(300 * 32 + 9);
        stop_now("loop_stop");
        drain(20);
        // stop mid-ramp at duty 4, then clean restart running three loops
        start_seq(1, 9, 2, 0, 3, 7, "ramp", n);
        tick_n(6);
        stop_now("ramp_stop");
        drain(20);
        start_seq(1, 9, 2, 0, 3, 130, "restart", n);
        drain(200);
        bad_cfg(7, 7, "cfg_eq");
        drain(10);
        bad_cfg(9, 3, "cfg_inv");
        drain(10);
        begin
            int s;
            s = cyc;
            min_duty = 4'd1;
            max_duty = 4'd5;
            start = 1'b1;
            stop = 1'b1;
            q.push_back('{s + 1, 7'd0, "start_stop"});
            q.push_back('{s + 2, 7'd0, "start_stop"});
            tick_n(1);
            start = 1'b0;
            stop = 1'b0;
            drain(10);
        end
        // reset while holding high, then a fresh start must replay identically
        start_seq(3, 6, 2, 200, 0, 20, "hold", n);
        tick_n(19);
        rst = 1'b1;
        q.push_back('{n + 21, 7'd0, "hold_rst"});
        q.push_back('{n + 22, 7'd0, "hold_rst"});
        tick_n(1);
        rst = 1'b0;
        drain(10);
        start_seq(3, 6, 2, 200, 0, 420, "fresh", n);
        tick_n(419);
        stop_now("fresh_stop");
        drain(20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
